// File: rtl/muxl2_pkg.sv
// Shared definitions for the two-lane L2 mux arbiter: default sizes,
// priority-state encodings and lane index constants.
package muxl2_pkg;

  localparam int DW_DEF        = 8;
  localparam int DEPTH_DEF     = 4;
  localparam int AF_THRESH_DEF = 3;

  typedef enum logic {
    PRI_00 = 1'b0,
    PRI_11 = 1'b1
  } pri_e;

  localparam logic LANE_00 = 1'b0;
  localparam logic LANE_11 = 1'b1;

endpackage

// File: rtl/muxl2_lane_fifo.sv
// Per-lane circular FIFO. The caller only raises pop when the FIFO is
// non-empty and only raises push when there is room or a pop happens the same edge.
module muxl2_lane_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/muxl2_arbiter.sv
// Two-lane round-robin arbiter feeding the L2 mux output, with per-lane FIFOs,
// almost-full pause flags and sticky overflow flags. Define MUXL2_ARB_CNT_EN for issue counters.
module muxl2_arbiter
  import muxl2_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF
) (
  input  logic          clk_4f,
  input  logic          reset,
  input  logic [DW-1:0] data_00,
  input  logic          valid_00,
  input  logic [DW-1:0] data_11,
  input  logic          valid_11,
  input  logic          pop,
  output logic [DW-1:0] data_000,
  output logic          valid_000,
  output logic          lane_sel,
  output logic          pause_00,
  output logic          pause_11,
  output logic          ovf_00,
  output logic          ovf_11
`ifdef MUXL2_ARB_CNT_EN
  ,
  output logic [7:0]    cnt_00,
  output logic [7:0]    cnt_11
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  function automatic logic [CW-1:0] post_count(input logic [CW-1:0] cnt,
                                               input logic push,
                                               input logic pull);
    return cnt + CW'(push) - CW'(pull);
  endfunction

  logic [DW-1:0] head_00, head_11;
  logic [CW-1:0] count_00, count_11;
  logic          full_00, full_11, empty_00, empty_11;
  logic          push_00, push_11, pull_00, pull_11;
  logic          grant_vld, grant_lane;

  pri_e          state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          lane_q, lane_d;
  logic          pause_00_q, pause_00_d, pause_11_q, pause_11_d;
  logic          ovf_00_q, ovf_00_d, ovf_11_q, ovf_11_d;

  muxl2_lane_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_00 (
    .clk   (clk_4f),
    .rst   (reset),
    .push  (push_00),
    .wdata (data_00),
    .pop   (pull_00),
    .head  (head_00),
    .count (count_00),
    .full  (full_00),
    .empty (empty_00)
  );

  muxl2_lane_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_11 (
    .clk   (clk_4f),
    .rst   (reset),
    .push  (push_11),
    .wdata (data_11),
    .pop   (pull_11),
    .head  (head_11),
    .count (count_11),
    .full  (full_11),
    .empty (empty_11)
  );

  // Priority always moves to the lane that was not granted.
  always_comb begin
    state_d    = state_q;
    grant_vld  = 1'b0;
    grant_lane = LANE_00;
    if (pop) begin
      if (!empty_00 && !empty_11) begin
        grant_vld  = 1'b1;
        grant_lane = (state_q == PRI_11) ? LANE_11 : LANE_00;
      end else if (!empty_00) begin
        grant_vld  = 1'b1;
        grant_lane = LANE_00;
      end else if (!empty_11) begin
        grant_vld  = 1'b1;
        grant_lane = LANE_11;
      end
      if (grant_vld) begin
        state_d = (grant_lane == LANE_11) ? PRI_00 : PRI_11;
      end
    end
  end

  // A full lane still accepts a write when its head leaves on the same edge.
  always_comb begin
    pull_00    = grant_vld && (grant_lane == LANE_00);
    pull_11    = grant_vld && (grant_lane == LANE_11);
    push_00    = valid_00 && (!full_00 || pull_00);
    push_11    = valid_11 && (!full_11 || pull_11);
    ovf_00_d   = ovf_00_q || (valid_00 && !push_00);
    ovf_11_d   = ovf_11_q || (valid_11 && !push_11);
    pause_00_d = post_count(count_00, push_00, pull_00) >= CW'(AF_THRESH);
    pause_11_d = post_count(count_11, push_11, pull_11) >= CW'(AF_THRESH);
    valid_d    = grant_vld;
    data_d     = data_q;
    lane_d     = lane_q;
    if (grant_vld) begin
      data_d = (grant_lane == LANE_11) ? head_11 : head_00;
      lane_d = grant_lane;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q    <= PRI_00;
      data_q     <= '0;
      valid_q    <= 1'b0;
      lane_q     <= LANE_00;
      pause_00_q <= 1'b0;
      pause_11_q <= 1'b0;
      ovf_00_q   <= 1'b0;
      ovf_11_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      lane_q     <= lane_d;
      pause_00_q <= pause_00_d;
      pause_11_q <= pause_11_d;
      ovf_00_q   <= ovf_00_d;
      ovf_11_q   <= ovf_11_d;
    end
  end

  assign data_000  = data_q;
  assign valid_000 = valid_q;
  assign lane_sel  = lane_q;
  assign pause_00  = pause_00_q;
  assign pause_11  = pause_11_q;
  assign ovf_00    = ovf_00_q;
  assign ovf_11    = ovf_11_q;

`ifdef MUXL2_ARB_CNT_EN
  logic [7:0] cnt_00_q, cnt_00_d, cnt_11_q, cnt_11_d;

  always_comb begin
    cnt_00_d = cnt_00_q + 8'(pull_00);
    cnt_11_d = cnt_11_q + 8'(pull_11);
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      cnt_00_q <= '0;
      cnt_11_q <= '0;
    end else begin
      cnt_00_q <= cnt_00_d;
      cnt_11_q <= cnt_11_d;
    end
  end

  assign cnt_00 = cnt_00_q;
  assign cnt_11 = cnt_11_q;
`endif

endmodule

// File: tb/tb_muxl2_arbiter.sv
// Self-checking bench for muxl2_arbiter: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_muxl2_arbiter;

  localparam int DW        = 8;
  localparam int DEPTH     = 4;
  localparam int AF_THRESH = 3;

  logic          clk_4f;
  logic          reset;
  logic [DW-1:0] data_00, data_11;
  logic          valid_00, valid_11, pop;
  logic [DW-1:0] data_000;
  logic          valid_000, lane_sel;
  logic          pause_00, pause_11, ovf_00, ovf_11;
  logic [7:0]    cnt_00, cnt_11;

  muxl2_arbiter #(.DW(DW), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_00   (data_00),
    .valid_00  (valid_00),
    .data_11   (data_11),
    .valid_11  (valid_11),
    .pop       (pop),
    .data_000  (data_000),
    .valid_000 (valid_000),
    .lane_sel  (lane_sel),
    .pause_00  (pause_00),
    .pause_11  (pause_11),
    .ovf_00    (ovf_00),
    .ovf_11    (ovf_11)
`ifdef MUXL2_ARB_CNT_EN
    ,
    .cnt_00    (cnt_00),
    .cnt_11    (cnt_11)
`endif
  );

`ifndef MUXL2_ARB_CNT_EN
  assign cnt_00 = 8'h00;
  assign cnt_11 = 8'h00;
`endif

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  // Reference model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_data;
  logic       exp_valid, exp_lane, exp_pri;
  logic       exp_pause0, exp_pause1, exp_ovf0, exp_ovf1;
  int         exp_cnt0, exp_cnt1;

  logic [7:0] w00 [4] = '{8'hff, 8'hee, 8'hbb, 8'haa};
  logic [7:0] w11 [4] = '{8'hdd, 8'hcc, 8'h99, 8'h88};
  logic [7:0] seq [8] = '{8'hff, 8'hdd, 8'hee, 8'hcc, 8'hbb, 8'h99, 8'haa, 8'h88};

  initial begin
    clk_4f = 1'b0;
    forever #5 clk_4f = ~clk_4f;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v0, input logic [7:0] d0,
                            input logic v1, input logic [7:0] d1, input logic p);
    int g;
    int s0;
    int s1;
    if (r) begin
      q0.delete();
      q1.delete();
      exp_valid = 1'b0; exp_data = 8'h00; exp_lane = 1'b0; exp_pri = 1'b0;
      exp_pause0 = 1'b0; exp_pause1 = 1'b0; exp_ovf0 = 1'b0; exp_ovf1 = 1'b0;
      exp_cnt0 = 0; exp_cnt1 = 0;
    end else begin
      s0 = q0.size();
      s1 = q1.size();
      g = -1;
      if (p) begin
        if (s0 > 0 && s1 > 0) g = exp_pri ? 1 : 0;
        else if (s0 > 0)      g = 0;
        else if (s1 > 0)      g = 1;
      end
      exp_valid = (g >= 0);
      if (g == 0) begin
        exp_data = q0.pop_front();
        exp_lane = 1'b0;
        exp_pri  = 1'b1;
        exp_cnt0 = (exp_cnt0 + 1) % 256;
      end else if (g == 1) begin
        exp_data = q1.pop_front();
        exp_lane = 1'b1;
        exp_pri  = 1'b0;
        exp_cnt1 = (exp_cnt1 + 1) % 256;
      end
      if (v0) begin
        if (s0 < DEPTH || g == 0) q0.push_back(d0);
        else exp_ovf0 = 1'b1;
      end
      if (v1) begin
        if (s1 < DEPTH || g == 1) q1.push_back(d1);
        else exp_ovf1 = 1'b1;
      end
      exp_pause0 = (q0.size() >= AF_THRESH);
      exp_pause1 = (q1.size() >= AF_THRESH);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, return at negedge.
  task automatic cyc(input logic r, input logic v0, input logic [7:0] d0,
                     input logic v1, input logic [7:0] d1, input logic p);
    reset = r; valid_00 = v0; data_00 = d0; valid_11 = v1; data_11 = d1; pop = p;
    @(posedge clk_4f);
    model_step(r, v0, d0, v1, d1, p);
    @(negedge clk_4f);
  endtask

  task automatic idle_pop();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  always @(negedge clk_4f) begin
    if (chk_en) begin
      check("valid_000", {31'd0, valid_000}, {31'd0, exp_valid});
      check("data_000", {24'd0, data_000}, {24'd0, exp_data});
      check("lane_sel", {31'd0, lane_sel}, {31'd0, exp_lane});
      check("pause_00", {31'd0, pause_00}, {31'd0, exp_pause0});
      check("pause_11", {31'd0, pause_11}, {31'd0, exp_pause1});
      check("ovf_00", {31'd0, ovf_00}, {31'd0, exp_ovf0});
      check("ovf_11", {31'd0, ovf_11}, {31'd0, exp_ovf1});
`ifdef MUXL2_ARB_CNT_EN
      check("cnt_00", {24'd0, cnt_00}, exp_cnt0[31:0]);
      check("cnt_11", {24'd0, cnt_11}, exp_cnt1[31:0]);
`endif
    end
  end

  initial begin
    int nvalid;
    reset = 1'b1; valid_00 = 1'b0; valid_11 = 1'b0; pop = 1'b0;
    data_00 = 8'h00; data_11 = 8'h00;

    // Reset state
    do_reset();
    chk_en = 1'b1;
    check("rst_valid", {31'd0, valid_000}, 32'd0);
    check("rst_data", {24'd0, data_000}, 32'd0);
    check("rst_pause", {30'd0, pause_00, pause_11}, 32'd0);
    check("rst_ovf", {30'd0, ovf_00, ovf_11}, 32'd0);

    // Single word on lane 00: written at edge 2, issued at edge 3
    cyc(1'b0, 1'b1, 8'h1f, 1'b0, 8'h00, 1'b1);
    check("t1_not_yet", {31'd0, valid_000}, 32'd0);
    idle_pop();
    check("t1_data", {24'd0, data_000}, 32'h1f);
    check("t1_valid", {31'd0, valid_000}, 32'd1);
    check("t1_lane", {31'd0, lane_sel}, 32'd0);
    check("t1_model_pri", {31'd0, exp_pri}, 32'd1);

    // Both lanes, four words each, then strict alternation
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, w00[i], 1'b1, w11[i], 1'b0);
    check("t2_pause_00", {31'd0, pause_00}, 32'd1);
    check("t2_pause_11", {31'd0, pause_11}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      idle_pop();
      check("t2_seq_data", {24'd0, data_000}, {24'd0, seq[i]});
      check("t2_seq_lane", {31'd0, lane_sel}, i % 2);
    end
    idle_pop();
    check("t2_empty_valid", {31'd0, valid_000}, 32'd0);
    check("t2_hold_data", {24'd0, data_000}, 32'h88);
    check("t2_hold_lane", {31'd0, lane_sel}, 32'd1);

    // Overfill lane 11 with pop low
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'(8'h10 + i), 1'b0);
      if (i == 1) check("t3_pause_low", {31'd0, pause_11}, 32'd0);
      if (i == 2) check("t3_pause_high", {31'd0, pause_11}, 32'd1);
      if (i == 3) check("t3_no_ovf_yet", {31'd0, ovf_11}, 32'd0);
    end
    check("t3_ovf", {31'd0, ovf_11}, 32'd1);
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      idle_pop();
      if (valid_000) nvalid++;
      if (i == 3) check("t3_last_word", {24'd0, data_000}, 32'h13);
    end
    check("t3_word_count", nvalid, 32'd4);
    check("t3_ovf_sticky", {31'd0, ovf_11}, 32'd1);

    // Full lane 00 written on the same edge its head is granted
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h44, 1'b0, 8'h00, 1'b1);
    check("t4_data", {24'd0, data_000}, 32'h40);
    check("t4_no_ovf", {31'd0, ovf_00}, 32'd0);
    check("t4_pause_kept", {31'd0, pause_00}, 32'd1);
    for (int i = 0; i < 4; i++) idle_pop();
    check("t4_tail", {24'd0, data_000}, 32'h44);

    // Reset with both lanes holding data, inputs active at the reset edge
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h50 + i), 1'b1, 8'(8'h60 + i), 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("t5_pri_moved", {31'd0, exp_pri}, 32'd1);
    cyc(1'b1, 1'b1, 8'h77, 1'b1, 8'h66, 1'b1);
    check("t5_rst_valid", {31'd0, valid_000}, 32'd0);
    check("t5_rst_ovf", {30'd0, ovf_00, ovf_11}, 32'd0);
    check("t5_rst_pause", {30'd0, pause_00, pause_11}, 32'd0);
    idle_pop();
    check("t5_flushed", {31'd0, valid_000}, 32'd0);
    cyc(1'b0, 1'b1, 8'ha0, 1'b1, 8'hb0, 1'b0);
    idle_pop();
    check("t5_first_lane", {31'd0, lane_sel}, 32'd0);
    check("t5_first_data", {24'd0, data_000}, 32'ha0);
    idle_pop();
    check("t5_second_data", {24'd0, data_000}, 32'hb0);

    // Mixed traffic against the model
    do_reset();
    for (int i = 0; i < 60; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 3) != 0));
    end

`ifdef MUXL2_ARB_CNT_EN
    // 300 lane-00 words issued; counter wraps to 44
    do_reset();
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0, 8'h00, 1'b1);
    idle_pop();
    check("t6_cnt_00", {24'd0, cnt_00}, 32'd44);
    check("t6_cnt_11", {24'd0, cnt_11}, 32'd0);
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
